// File: rtl/max_scan_unit.sv
// Array-scan engine on the data-memory read port: returns the signed maximum of
// N_WORDS consecutive words starting at BASE_ADDR and the index where it first occurs.
//
// state   | meaning
// IDLE    | waiting for start, previous results held
// SCAN    | one word read and compared per cycle
// DONE    | one-cycle done pulse, then back to IDLE
module max_scan_unit #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(1000),
  parameter int unsigned        N_WORDS    = 20,
  parameter int unsigned        WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_value,
  output logic [31:0]       max_index
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       idx_q, idx_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] max_value_q, max_value_d;
  logic [31:0]       max_index_q, max_index_d;
  logic              take;
  logic [31:0]       idx_next;

  // Outputs are registered, so the address for the next word is computed one
  // edge early; memory read is combinational and sampled in the cycle it is shown.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_adr_d   = '0;
    mem_rd_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    max_value_d = max_value_q;
    max_index_d = max_index_q;
    take        = 1'b0;
    idx_next    = idx_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          mem_adr_d = BASE_ADDR;
          mem_rd_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        take = (idx_q == 32'd0) || ($signed(mem_data) > $signed(max_value_q));
        if (take) begin
          max_value_d = mem_data;
          max_index_d = idx_q;
        end
        if (idx_q == N_WORDS - 1) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d     = idx_next;
          mem_adr_d = BASE_ADDR + ADDR_W'(idx_next * WORD_BYTES);
          mem_rd_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mem_adr_q   <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_value_q <= '0;
      max_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_adr_q   <= mem_adr_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      max_value_q <= max_value_d;
      max_index_q <= max_index_d;
    end
  end

  assign mem_adr   = mem_adr_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_value = max_value_q;
  assign max_index = max_index_q;

endmodule
